// File: rtl/sram_result_checker_if.sv
// sram_result_checker_if: single-outstanding SRAM read port between the checker (master) and the SRAM arbiter (slave).
interface sram_result_checker_if #(
  parameter int ADDR_W     = 20,
  parameter int SRAM_WIDTH = 256
);
  logic                  req;
  logic [ADDR_W-1:0]     addr;
  logic                  gnt;
  logic                  rvalid;
  logic [SRAM_WIDTH-1:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_result_checker.sv
// sram_result_checker: walks result/expected rows in SRAM, compares active INT32 lanes, reports pass/count/first failure.
// Optional SRAM_CHK_TOLERANCE_EN: a lane mismatches only when |act-exp| exceeds chk_tol.
module sram_result_checker #(
  parameter int SRAM_WIDTH = 256,
  parameter int ELEM_W     = 32,
  parameter int LANES      = SRAM_WIDTH / ELEM_W,
  parameter int ADDR_W     = 20,
  parameter int CNT_W      = 16,
  localparam int LW        = $clog2(LANES + 1),
  localparam int FW        = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    chk_start,
  input  logic [ADDR_W-1:0]       chk_res_addr,
  input  logic [ADDR_W-1:0]       chk_exp_addr,
  input  logic [CNT_W-1:0]        chk_rows,
  input  logic [LW-1:0]           chk_lanes,
  input  logic [ELEM_W-1:0]       chk_tol,
  sram_result_checker_if.master   mem,
  output logic                    chk_busy,
  output logic                    chk_done,
  output logic                    chk_pass,
  output logic [CNT_W-1:0]        chk_err_count,
  output logic [CNT_W-1:0]        chk_first_row,
  output logic [FW-1:0]           chk_first_lane
);
  typedef enum logic [2:0] {IDLE, REQ_RES, WAIT_RES, REQ_EXP, WAIT_EXP, CMP, DONE} state_t;
  state_t                state, nxt;
  logic [ADDR_W-1:0]     res_q, exp_q;
  logic [CNT_W-1:0]      rows_q, row;
  logic [LW-1:0]         lanes_q;
  logic [SRAM_WIDTH-1:0] res_word, exp_word;
  logic                  hit;
  logic [LANES-1:0]      mis;
  logic [CNT_W:0]        pop, sum;
  logic [FW-1:0]         first;
`ifdef SRAM_CHK_TOLERANCE_EN
  logic [ELEM_W-1:0]     tol_q;
`else
  logic                  unused_tol;
  assign unused_tol = ^chk_tol;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = chk_start ? (chk_rows == '0 ? DONE : REQ_RES) : IDLE;
      REQ_RES:  nxt = mem.gnt ? WAIT_RES : REQ_RES;
      WAIT_RES: nxt = mem.rvalid ? REQ_EXP : WAIT_RES;
      REQ_EXP:  nxt = mem.gnt ? WAIT_EXP : REQ_EXP;
      WAIT_EXP: nxt = mem.rvalid ? CMP : WAIT_EXP;
      CMP:      nxt = row == rows_q - CNT_W'(1) ? DONE : REQ_RES;
      default:  nxt = IDLE;
    endcase
  end
  always_comb begin
    mem.req  = state == REQ_RES || state == REQ_EXP;
    mem.addr = (state == REQ_EXP ? exp_q : res_q) + ADDR_W'(row);
    chk_busy = state != IDLE;
    chk_done = state == DONE;
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ELEM_W-1:0] a, e;
    assign a = res_word[l*ELEM_W +: ELEM_W];
    assign e = exp_word[l*ELEM_W +: ELEM_W];
`ifdef SRAM_CHK_TOLERANCE_EN
    // One extra bit keeps the signed difference and its magnitude overflow-free.
    logic [ELEM_W:0] d, ad;
    assign d  = {a[ELEM_W-1], a} - {e[ELEM_W-1], e};
    assign ad = d[ELEM_W] ? -d : d;
    assign mis[l] = LW'(l) < lanes_q && ad > {1'b0, tol_q};
`else
    assign mis[l] = LW'(l) < lanes_q && a != e;
`endif
  end
  always_comb begin
    pop   = '0;
    first = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      pop = pop + (CNT_W+1)'(mis[i]);
      first = mis[i] ? FW'(i) : first;
    end
  end
  assign sum = {1'b0, chk_err_count} + pop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_q          <= '0;
      exp_q          <= '0;
      rows_q         <= '0;
      lanes_q        <= '0;
      row            <= '0;
      res_word       <= '0;
      exp_word       <= '0;
      hit            <= 1'b0;
      chk_pass       <= 1'b0;
      chk_err_count  <= '0;
      chk_first_row  <= '0;
      chk_first_lane <= '0;
`ifdef SRAM_CHK_TOLERANCE_EN
      tol_q          <= '0;
`endif
    end else begin
      if (state == IDLE && chk_start) begin
        res_q          <= chk_res_addr;
        exp_q          <= chk_exp_addr;
        rows_q         <= chk_rows;
        lanes_q        <= chk_lanes == '0 ? LW'(LANES) : chk_lanes;
        row            <= '0;
        hit            <= 1'b0;
        chk_pass       <= 1'b0;
        chk_err_count  <= '0;
        chk_first_row  <= '0;
        chk_first_lane <= '0;
`ifdef SRAM_CHK_TOLERANCE_EN
        tol_q          <= chk_tol;
`endif
      end
      if (state == WAIT_RES && mem.rvalid) res_word <= mem.rdata;
      if (state == WAIT_EXP && mem.rvalid) exp_word <= mem.rdata;
      if (state == CMP) begin
        row           <= row + CNT_W'(1);
        chk_err_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        if (!hit && |mis) begin
          hit            <= 1'b1;
          chk_first_row  <= row;
          chk_first_lane <= first;
        end
      end
      // Entering DONE from IDLE means an empty run, which always passes.
      if (nxt == DONE) chk_pass <= state == IDLE || !(hit || |mis);
    end
endmodule

// File: tb/tb_sram_result_checker.sv
// tb_sram_result_checker: randomized scoreboard bench with an SRAM slave model (stalling grants, variable read latency).
module tb_sram_result_checker;
  localparam int SW = 256, EW = 32, LN = 8, AW = 20, CW = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic          chk_start = 1'b0;
  logic [AW-1:0] chk_res_addr = '0, chk_exp_addr = '0;
  logic [CW-1:0] chk_rows = '0;
  logic [3:0]    chk_lanes = '0;
  logic [EW-1:0] chk_tol = '0;
  logic          chk_busy, chk_done, chk_pass;
  logic [CW-1:0] chk_err_count, chk_first_row;
  logic [2:0]    chk_first_lane;
  sram_result_checker_if #(.ADDR_W(AW), .SRAM_WIDTH(SW)) mem ();
  sram_result_checker dut (
    .clk(clk), .rst_n(rst_n), .chk_start(chk_start), .chk_res_addr(chk_res_addr),
    .chk_exp_addr(chk_exp_addr), .chk_rows(chk_rows), .chk_lanes(chk_lanes), .chk_tol(chk_tol),
    .mem(mem), .chk_busy(chk_busy), .chk_done(chk_done), .chk_pass(chk_pass),
    .chk_err_count(chk_err_count), .chk_first_row(chk_first_row), .chk_first_lane(chk_first_lane)
  );
  typedef struct {bit pass; int cnt; int row; int lane;} res_t;
  res_t sb[$];
  res_t got;
  int checks = 0, fails = 0;
  logic [SW-1:0] sram [logic [AW-1:0]];
  int gnt_delay = 0, rd_lat = 1, stall = 0, lat_cnt = 0, req_cycles = 0;
  bit pend = 0, prev_wait = 0;
  logic [AW-1:0] prev_addr, pend_addr;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [SW-1:0] rd(input logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : '0;
  endfunction
  function automatic logic [SW-1:0] fill(input int v);
    logic [SW-1:0] w;
    for (int l = 0; l < LN; l++) w[l*EW +: EW] = v;
    return w;
  endfunction
  task automatic poke(input logic [AW-1:0] a, input int l, input int v);
    logic [SW-1:0] w;
    w = rd(a);
    w[l*EW +: EW] = v;
    sram[a] = w;
  endtask
  // Reference: count every active lane whose signed values differ (or differ by more than tol).
  function automatic res_t model(input logic [AW-1:0] rb, input logic [AW-1:0] eb, input int rows,
                                 input int lanes, input longint tol);
    res_t r;
    logic [SW-1:0] rw, ew;
    int a, e, n;
    longint d;
    bit bad;
    r = '{1'b1, 0, 0, 0};
    n = lanes == 0 ? LN : lanes;
    for (int i = 0; i < rows; i++) begin
      rw = rd(rb + AW'(i));
      ew = rd(eb + AW'(i));
      for (int l = 0; l < n; l++) begin
        a = rw[l*EW +: EW];
        e = ew[l*EW +: EW];
        d = longint'(a) - longint'(e);
`ifdef SRAM_CHK_TOLERANCE_EN
        bad = (d < 0 ? -d : d) > tol;
`else
        bad = d != 0 && tol >= 0;
`endif
        if (bad) begin
          if (r.cnt < 65535) r.cnt++;
          if (r.pass) begin
            r.pass = 1'b0;
            r.row  = i;
            r.lane = l;
          end
        end
      end
    end
    return r;
  endfunction
  initial begin
    mem.gnt = 1'b0;
    mem.rvalid = 1'b0;
    mem.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem.rvalid = 1'b0;
      mem.rdata = {8{$urandom}};
      if (pend) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          mem.rvalid = 1'b1;
          mem.rdata = rd(pend_addr);
          pend = 0;
        end
      end
      if (mem.req) req_cycles++;
      if (rst_n && mem.req && prev_wait) check("addr_stable", mem.addr, prev_addr);
      mem.gnt = 1'b0;
      prev_wait = 0;
      if (rst_n && mem.req) begin
        if (!pend && stall >= gnt_delay) begin
          mem.gnt = 1'b1;
          stall = 0;
          pend = 1;
          lat_cnt = rd_lat;
          pend_addr = mem.addr;
        end else begin
          stall++;
          prev_wait = 1;
          prev_addr = mem.addr;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n && chk_done) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        got = sb.pop_front();
        check("pass", chk_pass, got.pass);
        check("err_count", chk_err_count, got.cnt);
        check("first_row", chk_first_row, got.row);
        check("first_lane", chk_first_lane, got.lane);
      end
    end
  end
  task automatic issue(input logic [AW-1:0] rb, input logic [AW-1:0] eb, input int rows,
                       input int lanes, input logic [EW-1:0] tol);
    @(posedge clk);
    #1;
    chk_start = 1'b1;
    chk_res_addr = rb;
    chk_exp_addr = eb;
    chk_rows = CW'(rows);
    chk_lanes = 4'(lanes);
    chk_tol = tol;
    @(posedge clk);
    #1;
    chk_start = 1'b0;
    chk_res_addr = AW'($urandom);
    chk_exp_addr = AW'($urandom);
    chk_rows = CW'($urandom);
    chk_lanes = 4'($urandom);
    chk_tol = $urandom;
  endtask
  task automatic run(input logic [AW-1:0] rb, input logic [AW-1:0] eb, input int rows,
                     input int lanes, input logic [EW-1:0] tol);
    res_t e;
    int n;
    e = model(rb, eb, rows, lanes, longint'(tol));
    sb.push_back(e);
    issue(rb, eb, rows, lanes, tol);
    check("busy_after_start", chk_busy, 1);
    check("count_cleared", chk_err_count, 0);
    if (rows != 0) check("pass_cleared", chk_pass, 0);
    n = 0;
    while (!chk_done && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!chk_done) check("done_timeout", 0, 1);
    @(posedge clk);
    #1;
    check("idle_after_done", chk_busy, 0);
    check("pass_held", chk_pass, e.pass);
    sb.delete();
  endtask
  task automatic outs_zero(input string t);
    check({t, "_busy"}, chk_busy, 0);
    check({t, "_done"}, chk_done, 0);
    check({t, "_pass"}, chk_pass, 0);
    check({t, "_count"}, chk_err_count, 0);
    check({t, "_frow"}, chk_first_row, 0);
    check({t, "_flane"}, chk_first_lane, 0);
    check({t, "_req"}, mem.req, 0);
  endtask
  task automatic load_base(input bit upper);
    logic [SW-1:0] w;
    sram.delete();
    for (int r = 0; r < 4; r++) begin
      sram[AW'(32 + r)] = fill(r + 1);
      w = fill(r + 1);
      if (upper) for (int l = 4; l < LN; l++) w[l*EW +: EW] = 99;
      sram[AW'(64 + r)] = w;
    end
  endtask
  initial begin
    int n;
    logic [AW-1:0] rb, eb;
    logic [SW-1:0] rw, ew;
    repeat (3) @(posedge clk);
    #1;
    outs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    load_base(1);
    run(20'h20, 20'h40, 4, 4, 0);
    load_base(1);
    poke(20'h22, 3, 7);
    run(20'h20, 20'h40, 4, 4, 0);
    load_base(0);
    for (int l = 0; l < LN; l++) poke(20'h21, l, 1000 + l);
    poke(20'h23, 0, -5);
    run(20'h20, 20'h40, 4, 0, 0);
    req_cycles = 0;
    run(20'h20, 20'h40, 0, 4, 0);
    check("rows0_no_req", req_cycles, 0);
    load_base(1);
    gnt_delay = 5;
    rd_lat = 3;
    run(20'h20, 20'h40, 4, 4, 0);
    gnt_delay = 0;
    load_base(1);
    issue(20'h20, 20'h40, 4, 4, 0);
    n = 0;
    while (!(mem.req && mem.addr == 20'h42) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    while (mem.req && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_reached_wait_exp_row2", n < 1000, 1);
    rst_n = 1'b0;
    #2;
    outs_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run(20'h20, 20'h40, 4, 4, 0);
`ifdef SRAM_CHK_TOLERANCE_EN
    sram.delete();
    poke(20'h20, 0, 102);
    poke(20'h40, 0, 100);
    run(20'h20, 20'h40, 1, 1, 2);
    run(20'h20, 20'h40, 1, 1, 1);
`endif
    for (int k = 0; k < 24; k++) begin
      sram.delete();
      rb = ($urandom_range(0, 3) == 0) ? 20'hFFFFC : AW'($urandom);
      eb = rb + 20'h01000;
      n = $urandom_range(1, 6);
      gnt_delay = $urandom_range(0, 3);
      rd_lat = $urandom_range(1, 4);
      for (int r = 0; r < n; r++) begin
        for (int l = 0; l < LN; l++) ew[l*EW +: EW] = $urandom;
        rw = ew;
        for (int l = 0; l < LN; l++)
          if ($urandom_range(0, 3) == 0)
            case ($urandom_range(0, 2))
              0: rw[l*EW +: EW] = $urandom;
              1: rw[l*EW +: EW] = ew[l*EW +: EW] + (($urandom_range(0, 1) == 1) ? 32'd2 : -32'd1);
              default: begin
                rw[l*EW +: EW] = 32'h8000_0000;
                ew[l*EW +: EW] = 32'h7FFF_FFFF;
              end
            endcase
        sram[rb + AW'(r)] = rw;
        sram[eb + AW'(r)] = ew;
      end
      run(rb, eb, n, $urandom_range(0, 8), $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
